cla_word_sequencer: RTL
=======================

# cla_word_sequencer

Multi-cycle wide adder/subtractor built around the team's 4-bit carry-lookahead adder (`sumGenerator`). It accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds the CLA one nibble per clock, LSB first. A registered carry links the nibbles. It then presents the assembled sum, carry-out and signed-overflow flag on an output handshake. It sits directly upstream of the CLA, driving its A/B/Cin inputs and consuming its sum/Cout_final outputs.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8
- NIBBLES, WIDTH/4, derived; number of CLA passes per operation (not overridable)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  1: compute a − b (b inverted, carry-in forced 1)
- out_valid  output  1  result present (high only in DONE)
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  final carry-out; for sub, 1 = no borrow
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, at the clock edge:
  - latch a and (sub ? ~b : b) into operand shift registers
  - carry_reg ← sub ? 1 : cin
  - latch a[WIDTH-1], effective b[WIDTH-1]
  - clear nibble counter; go to RUN.
- RUN: CLA inputs are the low nibbles of the operand registers, with Cin = carry_reg. Each edge:
  - CLA sum shifts into the top of the result register (result ← {cla_sum, result[WIDTH-1:4]})
  - carry_reg ← Cout_final
  - operand registers shift right by 4
  - counter increments
  - the edge on which the counter equals NIBBLES−1 moves to DONE.
- DONE: out_valid=1.
  - sum = result register; cout = carry_reg
  - ovf = (a_msb == beff_msb) && (sum[WIDTH-1] != a_msb)
  - Held stable until out_ready; the edge with out_ready=1 returns to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- No bypass: a new operation cannot be accepted on the same edge a result is consumed.
- Width rules:
  - all arithmetic is modulo 2^WIDTH
  - the counter is $clog2(NIBBLES) bits and is not allowed to wrap
  - the carry between nibbles is always the registered Cout_final, never the combinational value.

## Timing
- Reset values (the next edge with rst=1):
  - state = IDLE; in_ready = 1
  - out_valid = 0, sum = 0, cout = 0, ovf = 0
  - counter, carry_reg and the operand registers = 0.
- rst has priority over every other event. Reset in RUN or DONE aborts the operation with no output, and in_ready is high in the following cycle.
- Latency: the accept edge is edge k; out_valid is high after edge k+NIBBLES (4 cycles for WIDTH=16).
- Throughput: one operation per NIBBLES+2 cycles when out_ready is held high.
- The CLA is combinational with gate delays. The clock period must exceed its worst-case settle time; the bench uses a period of 200 time units.

## Structure
- Shared package `cla_pkg`:
  - state enum {IDLE, RUN, DONE}
  - constant NIBBLE_W = 4
  - function for the ovf expression
- Exactly one sub-module: the existing `sumGenerator` (ports A, B, Cin, sum, Cout_final), instantiated once.
- The shift registers, counter and FSM are local to `cla_word_sequencer`.

## Test plan
- 0x1234 + 0x4321, cin=0, out_ready=1:
  - sum=0x5555, cout=0, ovf=0
  - out_valid rises 4 cycles after the accept edge and lasts 1 cycle.
- 0xFFFF + 0x0001, cin=0 (carry ripples through all 4 nibbles): sum=0x0000, cout=1, ovf=0.
- sub=1, 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0. Then 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
- 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. Then 0xFFFF + 0xFFFF with cin=1 → sum=0xFFFF, cout=1, ovf=0.
- Backpressure: out_ready held low for 10 cycles in DONE, with in_valid pulsed high and new a/b applied:
  - sum, cout and ovf stay stable; in_ready=0; the new input is not accepted
  - the out_ready=1 edge leads to IDLE; the next accept yields the correct fresh result.
- Reset asserted during the 2nd RUN cycle:
  - next cycle shows IDLE, in_ready=1, out_valid=0, sum=0
  - a following 0x00FF + 0x0001 yields 0x0100, cout=0.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, constants and helpers for the CLA word sequencer
//
// Purpose : FSM state encoding, nibble width and the signed-overflow rule.
// Contents: state_t, NIBBLE_W, calc_ovf().

package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Overflow occurs when both addends share a sign and the result's sign
    // differs from it. For subtraction, b_msb is the sign of the inverted b.
    function automatic logic calc_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/sumGenerator.sv
// rtl/sumGenerator.sv - 4-bit carry-lookahead adder
//
// Purpose: combinational nibble adder with lookahead carries.
// Ports  : A, B       - 4-bit addends
//          Cin        - carry in
//          sum        - 4-bit sum
//          Cout_final - carry out of bit 3

module sumGenerator (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout_final
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Each carry is expanded directly from generate/propagate terms so no
    // carry depends on the previous carry's logic.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign sum        = p ^ c[3:0];
    assign Cout_final = c[4];

endmodule

// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - multi-cycle WIDTH-bit add/sub over one 4-bit CLA
//
// Purpose: accepts an operand pair, feeds the CLA one nibble per clock
//          (LSB first) with a registered inter-nibble carry, then presents
//          sum, carry-out and signed overflow until consumed.
// Ports  : clk, rst (sync, active high)
//          in_valid/in_ready, a, b, cin, sub - operand handshake
//          out_valid/out_ready, sum, cout, ovf - result handshake

module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    b_eff;
    logic                carry_reg;
    logic                a_msb;
    logic                beff_msb;
    logic [CNT_W-1:0]    cnt;
    logic [NIBBLE_W-1:0] cla_sum;
    logic                cla_cout;
    logic                accept;
    logic                step;

    // Subtraction is a + ~b + 1; the +1 arrives through the carry register.
    assign b_eff  = sub ? ~b : b;
    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN);

    sumGenerator u_cla (
        .A          (a_reg[NIBBLE_W-1:0]),
        .B          (b_reg[NIBBLE_W-1:0]),
        .Cin        (carry_reg),
        .sum        (cla_sum),
        .Cout_final (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            beff_msb  <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= sub | cin;
            a_msb     <= a[WIDTH-1];
            beff_msb  <= b_eff[WIDTH-1];
            cnt       <= '0;
        end else if (step) begin
            // Nibbles enter at the top so after NIBBLES passes the first
            // nibble computed has been pushed down to bit 0.
            result    <= {cla_sum, result[WIDTH-1:NIBBLE_W]};
            carry_reg <= cla_cout;
            a_reg     <= a_reg >> NIBBLE_W;
            b_reg     <= b_reg >> NIBBLE_W;
            // Holds at LAST instead of wrapping; cleared on the next accept.
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum  = result;
    assign cout = carry_reg;
    assign ovf  = calc_ovf(a_msb, beff_msb, result[WIDTH-1]);

endmodule
